// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a 2-input NAND/NOR cell: sweeps a/b through 00..11,
// captures t0/t1 truth tables and compares them against expected tables.
module gate_sweep_ctrl #(
   parameter int unsigned DWELL  = 20,
   parameter logic [3:0]  EXP_T0 = 4'b0111,
   parameter logic [3:0]  EXP_T1 = 4'b0001
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_t0,
   input  logic       i_t1,
   output logic       o_a,
   output logic       o_b,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [3:0] o_tt0,
   output logic [3:0] o_tt1,
   output logic [3:0] o_err_mask
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_idx;
   logic            r_a;
   logic            r_b;
   logic            r_pass;
   logic [3:0]      r_tt0;
   logic [3:0]      r_tt1;
   logic [3:0]      r_err;
   logic            w_accept;
   logic            w_sample;
   logic [3:0]      w_tt0;
   logic [3:0]      w_tt1;
   logic [3:0]      w_err;

   assign w_accept = (r_state == S_IDLE) & i_start & ~i_abort;
   assign w_sample = (r_state == S_DRIVE) & ~i_abort & (r_cnt == CNT_LAST);

   // Tables including the sample taken this cycle, so the final
   // comparison sees bit 3 before it is written back.
   always_comb begin
      w_tt0        = r_tt0;
      w_tt1        = r_tt1;
      w_tt0[r_idx] = i_t0;
      w_tt1[r_idx] = i_t1;
      w_err        = (w_tt0 ^ EXP_T0) | (w_tt1 ^ EXP_T1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      o_busy = 1'b0;
      o_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_DRIVE;
         end
         S_DRIVE: begin
            o_busy = 1'b1;
            if (i_abort)                       w_next = S_IDLE;
            else if (w_sample && r_idx == 2'd3) w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_idx  <= 2'd0;
         r_a    <= 1'b0;
         r_b    <= 1'b0;
         r_pass <= 1'b0;
         r_tt0  <= 4'd0;
         r_tt1  <= 4'd0;
         r_err  <= 4'd0;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_idx  <= 2'd0;
         r_a    <= 1'b0;
         r_b    <= 1'b0;
         r_pass <= 1'b0;
         r_tt0  <= 4'd0;
         r_tt1  <= 4'd0;
         r_err  <= 4'd0;
      end else if (r_state == S_DRIVE) begin
         if (i_abort) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_a   <= 1'b0;
            r_b   <= 1'b0;
         end else if (w_sample) begin
            r_cnt <= '0;
            r_tt0 <= w_tt0;
            r_tt1 <= w_tt1;
            if (r_idx == 2'd3) begin
               r_idx  <= 2'd0;
               r_a    <= 1'b0;
               r_b    <= 1'b0;
               r_err  <= w_err;
               r_pass <= (w_err == 4'd0);
            end else begin
               r_idx      <= r_idx + 2'd1;
               {r_a, r_b} <= r_idx + 2'd1;
            end
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_a        = r_a;
   assign o_b        = r_b;
   assign o_pass     = r_pass;
   assign o_tt0      = r_tt0;
   assign o_tt1      = r_tt1;
   assign o_err_mask = r_err;

endmodule
